external_interrupt_controller: RTL and testbench

EXTERNAL_INTERRUPT_CONTROLLER -- requirements
Module: external_interrupt_controller

---
 rtl/external_interrupt_controller_pkg.sv | 29 ++
 rtl/external_interrupt_controller_edge.sv | 51 +++++
 rtl/external_interrupt_controller.sv | 160 ++++++++++++++++
 tb/tb_external_interrupt_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/external_interrupt_controller_pkg.sv
// Shared definitions for the external interrupt controller: register map, FSM encoding, ACTIVE layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package external_interrupt_controller_pkg;

  localparam logic [1:0] REG_PENDING  = 2'd0;
  localparam logic [1:0] REG_ENABLE   = 2'd1;
  localparam logic [1:0] REG_PRIORITY = 2'd2;
  localparam logic [1:0] REG_ACTIVE   = 2'd3;

  localparam int ACTIVE_VLD_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } eic_state_e;

  // High-class requests win over low-class ones; ties go to the lowest index.
  function automatic logic [3:0] pick_winner(input logic [15:0] req, input logic [15:0] hi);
    logic [15:0] cand;
    pick_winner = '0;
    cand = (|(req & hi)) ? (req & hi) : req;
    for (int i = 15; i >= 0; i--) begin
      if (cand[i]) pick_winner = 4'(i);
    end
  endfunction

endpackage

// File: rtl/external_interrupt_controller_edge.sv
// Per-source rising-edge detector; EIC_SYNC_EN adds a 2-flop synchronizer in front of it.
// Latency: pulse on the 1st clock edge after the line rises (3rd with EIC_SYNC_EN).
// Backpressure: none; one single-cycle pulse per rising edge of the line.
module InterruptEdgeDetector (
  input  logic clk,
  input  logic rst_n,
  input  logic src_irq,
  output logic edge_pulse
);

  logic line;
  logic hist_q;
  logic hist_d;

`ifdef EIC_SYNC_EN
  logic sync1_q;
  logic sync1_d;
  logic sync2_q;
  logic sync2_d;

  always_comb begin
    sync1_d = src_irq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign line = sync2_q;
`else
  assign line = src_irq;
`endif

  // History resets low so a line already high at reset release yields one pulse.
  assign hist_d = line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b0;
    else        hist_q <= hist_d;
  end

  assign edge_pulse = line & ~hist_q;

endmodule

// File: rtl/external_interrupt_controller.sv
// Edge-triggered interrupt controller with PENDING/ENABLE/PRIORITY/ACTIVE registers, non-nesting (EIC_SYNC_EN: sync inputs).
// Latency: request raised one edge after PENDING&ENABLE is seen; IO_DataR valid the cycle after IO_EnR.
// Backpressure: request held until EIC_IntAck; next request only after an ACTIVE write (end-of-interrupt).
module external_interrupt_controller
  import external_interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC  = 8,
  parameter logic [29:0] EIC_BASE = 30'h3FFF_FFF0
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_Irq,
  input  logic               IO_EnR,
  input  logic               IO_EnW,
  input  logic [29:0]        IO_Address,
  input  logic [31:0]        IO_DataW,
  output logic [31:0]        IO_DataR,
  output logic               EIC_IntReq,
  output logic               EIC_IntId,
  input  logic               EIC_IntAck
);

  logic [NUM_SRC-1:0] src_edge;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
    InterruptEdgeDetector u_edge (
      .clk        (Sys_Clock),
      .rst_n      (Sys_Reset),
      .src_irq    (Src_Irq[g]),
      .edge_pulse (src_edge[g])
    );
  end

  eic_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] prio_q, prio_d;
  logic [3:0]         winner_q, winner_d;
  logic               id_q, id_d;
  logic               act_vld_q, act_vld_d;
  logic [3:0]         act_src_q, act_src_d;
  logic [31:0]        data_r_q, data_r_d;

  logic [29:0]        offset;
  logic               in_range;
  logic               eoi_wr;
  logic [15:0]        req16;
  logic [15:0]        hi16;
  logic [3:0]         cand_win;
  logic               cand_hi;
  logic [NUM_SRC-1:0] win_mask;
  logic [31:0]        rd_val;
  logic               unused_dataw;

  // Modular distance from the base: in range exactly when it is below 4.
  assign offset       = IO_Address - EIC_BASE;
  assign in_range     = (offset[29:2] == '0);
  assign unused_dataw = ^IO_DataW;

  always_comb begin
    req16 = '0;
    hi16  = '0;
    req16[NUM_SRC-1:0] = pending_q & enable_q;
    hi16[NUM_SRC-1:0]  = prio_q;
    cand_win = pick_winner(req16, hi16);
    cand_hi  = hi16[cand_win];
    win_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) win_mask[i] = (winner_q == 4'(i));

    rd_val = '0;
    case (offset[1:0])
      REG_PENDING:  rd_val[NUM_SRC-1:0] = pending_q;
      REG_ENABLE:   rd_val[NUM_SRC-1:0] = enable_q;
      REG_PRIORITY: rd_val[NUM_SRC-1:0] = prio_q;
      REG_ACTIVE: begin
        rd_val[ACTIVE_VLD_BIT] = act_vld_q;
        rd_val[3:0]            = act_src_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    enable_d  = enable_q;
    prio_d    = prio_q;
    winner_d  = winner_q;
    id_d      = id_q;
    act_vld_d = act_vld_q;
    act_src_d = act_src_q;
    data_r_d  = (IO_EnR && in_range) ? rd_val : '0;
    eoi_wr    = IO_EnW && in_range && (offset[1:0] == REG_ACTIVE);

    if (IO_EnW && in_range) begin
      case (offset[1:0])
        REG_PENDING:  pending_d = pending_q & ~IO_DataW[NUM_SRC-1:0];
        REG_ENABLE:   enable_d  = IO_DataW[NUM_SRC-1:0];
        REG_PRIORITY: prio_d    = IO_DataW[NUM_SRC-1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (|(pending_q & enable_q)) begin
          state_d  = REQ;
          winner_d = cand_win;
          id_d     = cand_hi;
        end
      end
      REQ: begin
        if (EIC_IntAck) begin
          state_d   = SERVICE;
          pending_d = pending_d & ~win_mask;
          act_vld_d = 1'b1;
          act_src_d = winner_q;
        end
      end
      SERVICE: begin
        if (eoi_wr) begin
          state_d   = IDLE;
          act_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // New edges win over W1C and ack clears in the same cycle.
    pending_d = pending_d | src_edge;
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      prio_q    <= '0;
      winner_q  <= '0;
      id_q      <= 1'b0;
      act_vld_q <= 1'b0;
      act_src_q <= '0;
      data_r_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      prio_q    <= prio_d;
      winner_q  <= winner_d;
      id_q      <= id_d;
      act_vld_q <= act_vld_d;
      act_src_q <= act_src_d;
      data_r_q  <= data_r_d;
    end
  end

  assign IO_DataR   = data_r_q;
  assign EIC_IntReq = (state_q == REQ);
  assign EIC_IntId  = (state_q == REQ) && id_q;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Directed plus random bench for external_interrupt_controller against a rule-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_external_interrupt_controller;

  localparam int          NS   = 8;
  localparam logic [29:0] BASE = 30'h3FFF_FFF0;
`ifdef EIC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          Sys_Clock = 1'b0;
  logic          Sys_Reset = 1'b0;
  logic [NS-1:0] Src_Irq = '0;
  logic          IO_EnR = 1'b0;
  logic          IO_EnW = 1'b0;
  logic [29:0]   IO_Address = '0;
  logic [31:0]   IO_DataW = '0;
  logic [31:0]   IO_DataR;
  logic          EIC_IntReq;
  logic          EIC_IntId;
  logic          EIC_IntAck = 1'b0;

  always #5 Sys_Clock = ~Sys_Clock;

  external_interrupt_controller #(.NUM_SRC(NS), .EIC_BASE(BASE)) dut (
    .Sys_Clock  (Sys_Clock),
    .Sys_Reset  (Sys_Reset),
    .Src_Irq    (Src_Irq),
    .IO_EnR     (IO_EnR),
    .IO_EnW     (IO_EnW),
    .IO_Address (IO_Address),
    .IO_DataW   (IO_DataW),
    .IO_DataR   (IO_DataR),
    .EIC_IntReq (EIC_IntReq),
    .EIC_IntId  (EIC_IntId),
    .EIC_IntAck (EIC_IntAck)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: register contents plus "offered" / "in service" flags.
  logic [NS-1:0] m_pend, m_en, m_prio;
  logic          m_act_vld;
  logic [3:0]    m_act_src;
  bit            m_offered, m_busy;
  int            m_win;
  logic          m_id;
  logic [31:0]   m_rd;
  logic [NS-1:0] samp [0:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input int off);
    logic [31:0] v;
    v = '0;
    case (off)
      0: v[NS-1:0] = m_pend;
      1: v[NS-1:0] = m_en;
      2: v[NS-1:0] = m_prio;
      3: v = {m_act_vld, 27'd0, m_act_src};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_prio = '0;
    m_act_vld = 1'b0; m_act_src = '0;
    m_offered = 0; m_busy = 0; m_win = 0; m_id = 1'b0; m_rd = '0;
    for (int k = 0; k < 4; k++) samp[k] = '0;
  endtask

  task automatic model_edge();
    logic [NS-1:0] fire, old_pend, old_en, old_prio;
    logic [29:0]   diff;
    bit            hit, was_offered, was_busy;
    int            off;
    for (int k = 3; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = Src_Irq;
    fire = samp[LAT-1] & ~samp[LAT];
    diff = IO_Address - BASE;
    hit  = (diff < 30'd4);
    off  = int'(diff[1:0]);
    old_pend = m_pend; old_en = m_en; old_prio = m_prio;
    was_offered = m_offered; was_busy = m_busy;
    m_rd = (IO_EnR && hit) ? m_reg(off) : 32'd0;
    if (IO_EnW && hit) begin
      if (off == 0) m_pend = m_pend & ~IO_DataW[NS-1:0];
      if (off == 1) m_en = IO_DataW[NS-1:0];
      if (off == 2) m_prio = IO_DataW[NS-1:0];
      if (off == 3 && was_busy) begin
        m_act_vld = 1'b0;
        m_busy = 0;
      end
    end
    if (was_offered && EIC_IntAck) begin
      m_pend[m_win] = 1'b0;
      m_act_vld = 1'b1;
      m_act_src = 4'(m_win);
      m_offered = 0;
      m_busy = 1;
    end
    if (!was_offered && !was_busy && (old_pend & old_en) != '0) begin
      m_win = -1;
      for (int i = 0; i < NS; i++)
        if (m_win < 0 && old_pend[i] && old_en[i] && old_prio[i]) m_win = i;
      for (int i = 0; i < NS; i++)
        if (m_win < 0 && old_pend[i] && old_en[i]) m_win = i;
      m_id = old_prio[m_win];
      m_offered = 1;
    end
    m_pend = m_pend | fire;
  endtask

  task automatic tick();
    @(posedge Sys_Clock);
    if (!Sys_Reset) model_reset();
    else            model_edge();
    #1;
    chk("int_req", 32'(EIC_IntReq), 32'(m_offered));
    chk("int_id", 32'(EIC_IntId), 32'(m_offered ? m_id : 1'b0));
    chk("data_r", IO_DataR, m_rd);
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    IO_EnW = 1'b1; IO_Address = BASE + 30'(off); IO_DataW = data;
    tick();
    IO_EnW = 1'b0;
  endtask

  task automatic rd(input int off, output logic [31:0] data);
    IO_EnR = 1'b1; IO_Address = BASE + 30'(off);
    tick();
    data = IO_DataR;
    IO_EnR = 1'b0;
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    while (EIC_IntReq !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    EIC_IntAck = 1'b1;
    tick();
    EIC_IntAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int n;
    model_reset();

    // Reset state
    repeat (2) tick();
    chk("rst_int_req", 32'(EIC_IntReq), 32'd0);
    chk("rst_data_r", IO_DataR, 32'd0);
    Sys_Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      chk($sformatf("rst_reg%0d", i), v, 32'd0);
    end

    // Single source: latency, class, ack, ACTIVE, EOI
    wr(1, 32'h01);
    Src_Irq[0] = 1'b1;
    wait_req(12, n);
    chk("lat_src0", 32'(n), 32'(LAT + 1));
    chk("id_src0", 32'(EIC_IntId), 32'd0);
    ack();
    rd(3, v); chk("active_src0", v, 32'h8000_0000);
    rd(0, v); chk("pend_after_ack", v, 32'd0);
    wr(3, 32'd0);
    rd(3, v); chk("active_eoi", v, 32'd0);

    // Priority: high class first, then lowest index; offer stable under reg changes
    Src_Irq = '0;
    tick();
    wr(1, 32'hFF);
    wr(2, 32'h20);
    Src_Irq[1] = 1'b1; Src_Irq[5] = 1'b1;
    wait_req(12, n);
    chk("prio_req", 32'(EIC_IntReq), 32'd1);
    chk("prio_id_hi", 32'(EIC_IntId), 32'd1);
    wr(2, 32'h00);
    wr(1, 32'h00);
    chk("stable_req", 32'(EIC_IntReq), 32'd1);
    chk("stable_id", 32'(EIC_IntId), 32'd1);
    wr(1, 32'hFF);
    wr(2, 32'h20);
    ack();
    rd(3, v); chk("active_src5", v, 32'h8000_0005);
    wr(3, 32'd0);
    wait_req(12, n);
    chk("second_req", 32'(EIC_IntReq), 32'd1);
    chk("second_id_lo", 32'(EIC_IntId), 32'd0);
    ack();
    rd(3, v); chk("active_src1", v, 32'h8000_0001);
    wr(3, 32'd0);

    // Edge and W1C on the same bit in the same cycle
    Src_Irq = '0;
    tick();
    Src_Irq[2] = 1'b1;
    repeat (LAT - 1) tick();
    wr(0, 32'h04);
    rd(0, v); chk("w1c_vs_edge", v, 32'h04);
    wait_req(12, n);
    ack();
    wr(3, 32'd0);

    // Reset while a request is offered
    Src_Irq = '0;
    Src_Irq[3] = 1'b1;
    wait_req(12, n);
    chk("pre_rst_req", 32'(EIC_IntReq), 32'd1);
    Sys_Reset = 1'b0;
    #1;
    chk("rst_drop_req", 32'(EIC_IntReq), 32'd0);
    chk("rst_drop_id", 32'(EIC_IntId), 32'd0);
    Src_Irq = '0;
    tick();
    Sys_Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      chk($sformatf("mid_rst_reg%0d", i), v, 32'd0);
    end

    // Ack in IDLE, out-of-range and stray ACTIVE writes change nothing
    wr(2, 32'h5A);
    ack();
    wr(4, 32'hFFFF_FFFF);
    wr(-1, 32'hFFFF_FFFF);
    wr(3, 32'hFFFF_FFFF);
    rd(4, v); chk("oor_read", v, 32'd0);
    rd(0, v); chk("idle_pend", v, 32'd0);
    rd(1, v); chk("idle_en", v, 32'd0);
    rd(2, v); chk("idle_prio", v, 32'h5A);
    rd(3, v); chk("idle_active", v, 32'd0);

    // Simultaneous read and write returns pre-write data; upper bits read 0
    IO_EnR = 1'b1; IO_EnW = 1'b1; IO_Address = BASE + 30'd1; IO_DataW = 32'h33;
    tick();
    chk("rw_prewrite", IO_DataR, 32'd0);
    IO_EnR = 1'b0; IO_EnW = 1'b0;
    rd(1, v); chk("rw_written", v, 32'h33);
    wr(1, 32'hFFFF_FFFF);
    rd(1, v); chk("en_upper_zero", v, 32'hFF);

    // Random traffic against the model
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 3) == 0) Src_Irq = NS'($urandom);
      EIC_IntAck = ($urandom_range(0, 3) == 0);
      IO_EnR     = 1'($urandom_range(0, 1));
      IO_EnW     = ($urandom_range(0, 4) == 0);
      IO_Address = BASE + 30'($urandom_range(0, 5)) - 30'd1;
      IO_DataW   = $urandom;
      Sys_Reset  = (c != 450);
      tick();
    end
    Sys_Reset = 1'b1;
    EIC_IntAck = 1'b0; IO_EnR = 1'b0; IO_EnW = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
